tv_diff_engine: RTL and testbench
=================================

TV_DIFF_ENGINE -- requirements
Module: tv_diff_engine

Interface
REQ-001 The block SHALL expose parameter LANES, default 32, as the number of DATA_W-bit samples per memory word.
REQ-002 The block SHALL expose parameter DATA_W, default 16, as the signed two's-complement sample width.
REQ-003 The block SHALL expose parameter COLS, default 2, as the number of words per image row.
REQ-004 The block SHALL expose parameter ROWS, default 48, as the number of image rows.
REQ-005 The block SHALL expose parameter ADDR_W, default 8, as the word-address width, with ROWS*COLS <= 2^ADDR_W.
REQ-006 The block SHALL have port clk, input, 1 bit, as the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, as the reset; reset is synchronous and active-high.
REQ-008 The block SHALL have port start, input, 1 bit, as a one-cycle request to process one frame.
REQ-009 The block SHALL have port mode, input, 1 bit, selecting the difference: 0 = horizontal (dx), 1 = vertical (dy).
REQ-010 The block SHALL have port rd_en, output, 1 bit, as the source-memory read strobe.
REQ-011 The block SHALL have port rd_addr, output, ADDR_W bits, as the source word address.
REQ-012 The block SHALL have port rd_data, input, LANES*DATA_W bits, as the source word; lane k is bits [k*DATA_W +: DATA_W].
REQ-013 The block SHALL have port wr_en, output, 1 bit, as the destination-memory write strobe.
REQ-014 The block SHALL have port wr_addr, output, ADDR_W bits, as the destination word address.
REQ-015 The block SHALL have port wr_data, output, LANES*DATA_W bits, as the difference word, using the same lane packing as rd_data.
REQ-016 The block SHALL have port busy, output, 1 bit, which is high from the cycle after an accepted start until done.
REQ-017 The block SHALL have port done, output, 1 bit, as a one-cycle pulse marking frame completion.

Function
REQ-018 The block SHALL implement FSM states IDLE, READ, DRAIN and FIN.
- IDLE -> READ on start; start is ignored in any other state.
- READ -> DRAIN after the read of address 0.
- DRAIN -> FIN after the last write.
- FIN -> IDLE after one cycle.
REQ-019 The block SHALL register mode when start is accepted; mode changes during a frame have no effect.
REQ-020 In READ, the block SHALL assert rd_en for ROWS*COLS consecutive cycles, with rd_addr running from ROWS*COLS-1 down to 0 (address = row*COLS + col).
REQ-021 The block SHALL treat source memory read latency as exactly one cycle: rd_data is valid the cycle after rd_en.
REQ-022 For each word, the block SHALL assert wr_en exactly 2 cycles after the corresponding rd_en, with wr_addr equal to that rd_addr; the write stream is gap-free.
REQ-023 In dx mode, the block SHALL compute wr_data lane k (k < LANES-1) as x[k+1] - x[k].
- Lane LANES-1 = lane 0 of word col+1 (the previously read word) minus x[LANES-1].
- For col = COLS-1, lane LANES-1 SHALL be 0 (Neumann boundary).
REQ-024 In dy mode, the block SHALL compute each lane as the same lane/col of row+1 minus the current value.
- Row ROWS-1 SHALL produce all-zero words.
- A COLS-entry row buffer SHALL hold the row+1 words.
REQ-025 The dx carry register and the dy row buffer SHALL be cleared at start of every frame, so the previous frame never leaks into the next.
REQ-026 The block SHALL assert done in FIN for one cycle, exactly ROWS*COLS+3 cycles after the start cycle.
REQ-027 The block SHALL hold rd_en and wr_en low in IDLE and FIN.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL drive the FSM to IDLE.
- rd_en, wr_en, busy and done SHALL be 0.
- rd_addr, wr_addr and wr_data SHALL be 0.
- The carry register and row buffer SHALL be cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further writes, and the block SHALL accept a new start on the first cycle after rst deasserts.

Configuration
REQ-030 With macro TV_DIFF_SAT_EN defined, the block SHALL saturate each difference to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-031 Without TV_DIFF_SAT_EN, the block SHALL wrap each difference modulo 2^DATA_W.

Verification
REQ-032 The bench SHALL cover: defaults, dx mode, every sample = its lane index + 32*col -> every lane writes 1, except row-end lane 31 of col 1, which writes 0; 96 writes; done at cycle 99.
REQ-033 The bench SHALL cover: dy mode, every sample = row number -> rows 0..46 write all 1s and row 47 writes all 0s; wr_addr runs 95 down to 0.
REQ-034 The bench SHALL cover: dx mode, lane1 = 0x7FFF and lane0 = 0x8000 -> lane0 difference is 0x7FFF with TV_DIFF_SAT_EN and 0xFFFF without it.
REQ-035 The bench SHALL cover: rst raised at the 40th write -> no further wr_en; after release, start restarts from rd_addr 95 with a clean carry.
REQ-036 The bench SHALL cover: start pulsed during busy, and mode toggled mid-frame -> no restart, and output matches the latched mode.
REQ-037 The bench SHALL cover: a non-default configuration LANES=4, COLS=3, ROWS=5 with a ramp input -> results match the reference model bit-exactly, with done at cycle 18.

Source files
------------

// File: rtl/tv_diff_engine.sv
`default_nettype none
// ============================================================================
// Module   : tv_diff_engine
// Brief    : Frame-wide forward difference (dx or dy) over a LANES-wide memory.
//            Define TV_DIFF_SAT_EN to saturate differences instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module tv_diff_engine #(
    parameter int LANES  = 32,
    parameter int DATA_W = 16,
    parameter int COLS   = 2,
    parameter int ROWS   = 48,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [LANES*DATA_W-1:0]   rd_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam int c_NWORDS = ROWS * COLS;
    localparam int c_WORD_W = LANES * DATA_W;
    localparam int c_COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic                 mode_q,    mode_d;
    logic                 rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 vld_q,     vld_d;
    logic [ADDR_W-1:0]    vaddr_q,   vaddr_d;
    logic [c_COL_W-1:0]   col_q,     col_d;
    logic [c_ROW_W-1:0]   row_q,     row_d;
    logic [DATA_W-1:0]    carry_q,   carry_d;
    logic [c_WORD_W-1:0]  rowbuf_q [COLS];
    logic [c_WORD_W-1:0]  rowbuf_d [COLS];
    logic                 wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [c_WORD_W-1:0]  wr_data_q, wr_data_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [c_WORD_W-1:0]  w_diff;

    function automatic logic [DATA_W-1:0] diff_f(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef TV_DIFF_SAT_EN
        logic [DATA_W:0] d;
        d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        if (d[DATA_W] != d[DATA_W-1])
            return d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return d[DATA_W-1:0];
`else
        return a - b;
`endif
    endfunction

    // col_q/row_q track the word whose data is on rd_data this cycle
    always_comb begin
        w_diff = '0;
        if (!mode_q) begin
            for (int k = 0; k < LANES - 1; k++)
                w_diff[k*DATA_W +: DATA_W] = diff_f(rd_data[(k+1)*DATA_W +: DATA_W],
                                                    rd_data[k*DATA_W +: DATA_W]);
            if (col_q != c_COL_W'(COLS - 1))
                w_diff[(LANES-1)*DATA_W +: DATA_W] = diff_f(carry_q,
                                                            rd_data[(LANES-1)*DATA_W +: DATA_W]);
        end else if (row_q != c_ROW_W'(ROWS - 1)) begin
            for (int k = 0; k < LANES; k++)
                w_diff[k*DATA_W +: DATA_W] = diff_f(rowbuf_q[col_q][k*DATA_W +: DATA_W],
                                                    rd_data[k*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        vld_d     = rd_en_q;
        vaddr_d   = rd_addr_q;
        col_d     = col_q;
        row_d     = row_q;
        carry_d   = carry_q;
        rowbuf_d  = rowbuf_q;
        wr_en_d   = vld_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (vld_q) begin
            wr_addr_d        = vaddr_q;
            wr_data_d        = w_diff;
            carry_d          = rd_data[DATA_W-1:0];
            rowbuf_d[col_q]  = rd_data;
            if (col_q == '0) begin
                col_d = c_COL_W'(COLS - 1);
                row_d = row_q - c_ROW_W'(1);
            end else begin
                col_d = col_q - c_COL_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    mode_d    = mode;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'(c_NWORDS - 1);
                    busy_d    = 1'b1;
                    col_d     = c_COL_W'(COLS - 1);
                    row_d     = c_ROW_W'(ROWS - 1);
                    carry_d   = '0;
                    for (int c = 0; c < COLS; c++)
                        rowbuf_d[c] = '0;
                end
            end
            READ: begin
                if (rd_addr_q == '0) begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q - ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (wr_en_q && (wr_addr_q == '0)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= 1'b0;
            vaddr_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            carry_q   <= '0;
            for (int c = 0; c < COLS; c++)
                rowbuf_q[c] <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            vld_q     <= vld_d;
            vaddr_q   <= vaddr_d;
            col_q     <= col_d;
            row_q     <= row_d;
            carry_q   <= carry_d;
            rowbuf_q  <= rowbuf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tv_diff_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_tv_diff_engine
// Brief    : Table-driven frame tests of tv_diff_engine (default and small
//            configurations) against an image-level difference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tv_diff_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, mode, sel;
    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic         a_rd_en, a_wr_en, a_busy, a_done;
    logic [7:0]   a_rd_addr, a_wr_addr;
    logic [511:0] a_rd_data, a_wr_data;
    logic         b_rd_en, b_wr_en, b_busy, b_done;
    logic [7:0]   b_rd_addr, b_wr_addr;
    logic [63:0]  b_rd_data, b_wr_data;

    tv_diff_engine u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done)
    );

    tv_diff_engine #(.LANES(4), .DATA_W(16), .COLS(3), .ROWS(5), .ADDR_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done)
    );

    // View of whichever DUT the current test targets
    logic         w_rd_en, w_wr_en, w_busy, w_done;
    logic [7:0]   w_rd_addr, w_wr_addr;
    logic [511:0] w_wr_data;
    assign w_rd_en   = sel ? b_rd_en   : a_rd_en;
    assign w_wr_en   = sel ? b_wr_en   : a_wr_en;
    assign w_busy    = sel ? b_busy    : a_busy;
    assign w_done    = sel ? b_done    : a_done;
    assign w_rd_addr = sel ? b_rd_addr : a_rd_addr;
    assign w_wr_addr = sel ? b_wr_addr : a_wr_addr;
    assign w_wr_data = sel ? {448'd0, b_wr_data} : a_wr_data;

    // Image as signed samples: img[row][global column]
    int img [48][64];

    function automatic logic [511:0] pack_word(input int addr, input int lanes, input int cols);
        logic [511:0] w;
        int r;
        int c;
        w = '0;
        r = addr / cols;
        c = addr % cols;
        if (r < 48)
            for (int k = 0; k < lanes; k++)
                w[k*16 +: 16] = 16'(img[r][c*lanes + k]);
        return w;
    endfunction

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= pack_word(int'(a_rd_addr), 32, 2);
        if (b_rd_en) b_rd_data <= 64'(pack_word(int'(b_rd_addr), 4, 3));
    end

    function automatic int fix(input int d);
        int v;
        v = d;
`ifdef TV_DIFF_SAT_EN
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v & 32'hFFFF;
    endfunction

    // Forward difference with zero at the right/bottom image border
    function automatic int ref_sample(input bit m, input int r, input int j,
                                      input int rows, input int w);
        if (!m) return (j == w - 1) ? 0 : fix(img[r][j+1] - img[r][j]);
        return (r == rows - 1) ? 0 : fix(img[r+1][j] - img[r][j]);
    endfunction

    function automatic int lane_of(input int k);
        return int'(w_wr_data[k*16 +: 16]);
    endfunction

    typedef struct {
        bit sel;
        bit mode;
        int pat;
        bit midpulse;
        int abort_at;
        int exp_done;
        int s1_addr;
        int s1_lane;
        int s1_val;
        int s2_addr;
        int s2_lane;
        int s2_val;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int pat, input int rows, input int w);
        logic [15:0] t;
        for (int r = 0; r < rows; r++)
            for (int j = 0; j < w; j++) begin
                case (pat)
                    0: img[r][j] = j;
                    1: img[r][j] = r;
                    2: img[r][j] = (j % 32 == 1) ? 32767 : ((j % 32 == 0) ? -32768 : 0);
                    3: img[r][j] = r * w + j;
                    default: begin
                        t = 16'($urandom);
                        img[r][j] = int'($signed(t));
                    end
                endcase
            end
    endtask

    // Expects start already driven at the current negedge; walks one frame
    task automatic body(input vec_t v, input int abort_at, output int nwr);
        int lanes, cols, rows, n, w;
        bit got_done;
        bit stop;
        lanes = v.sel ? 4 : 32;
        cols  = v.sel ? 3 : 2;
        rows  = v.sel ? 5 : 48;
        n     = rows * cols;
        w     = lanes * cols;
        got_done = 1'b0;
        stop     = 1'b0;
        nwr      = 0;
        for (int rel = 1; rel <= n + 10 && !stop; rel++) begin
            @(negedge clk);
            if (rel == 1) begin
                start = 1'b0;
                chk("busy_in_frame", w_busy, 1);
            end
            if (v.midpulse && rel == 20) begin
                start = 1'b1;
                mode  = ~v.mode;
            end
            if (v.midpulse && rel == 21) start = 1'b0;
            chk("rd_en", w_rd_en, (rel <= n) ? 1 : 0);
            if (rel <= n) chk("rd_addr", w_rd_addr, n - rel);
            if (w_wr_en) begin
                int a, r, c, bad, k2;
                a   = n - 1 - nwr;
                r   = a / cols;
                c   = a % cols;
                bad = -1;
                chk("wr_addr", w_wr_addr, a);
                chk("wr_latency", rel, nwr + 3);
                for (int k = 0; k < lanes; k++)
                    if (lane_of(k) != ref_sample(v.mode, r, c*lanes + k, rows, w) && bad < 0)
                        bad = k;
                k2 = (bad < 0) ? 0 : bad;
                chk("wr_data", lane_of(k2), ref_sample(v.mode, r, c*lanes + k2, rows, w));
                if (a == v.s1_addr) chk("spot1", lane_of(v.s1_lane), v.s1_val);
                if (a == v.s2_addr) chk("spot2", lane_of(v.s2_lane), v.s2_val);
                nwr++;
                if (abort_at > 0 && nwr == abort_at) stop = 1'b1;
            end
            if (w_done) begin
                chk("done_cycle", rel, v.exp_done);
                got_done = 1'b1;
                stop     = 1'b1;
            end
        end
        if (abort_at == 0) begin
            chk("done_seen", got_done, 1);
            chk("n_writes", nwr, n);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int nwr;
        int rows, w;
        rows = v.sel ? 5 : 48;
        w    = v.sel ? 12 : 64;
        fill(v.pat, rows, w);
        @(negedge clk);
        sel   = v.sel;
        mode  = v.mode;
        start = 1'b1;
        body(v, v.abort_at, nwr);
        if (v.abort_at > 0) begin
            chk("abort_writes", nwr, v.abort_at);
            rst = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("rst_outputs", {w_rd_en, w_wr_en, w_busy, w_done,
                                    w_rd_addr, w_wr_addr, |w_wr_data}, 0);
            end
            fill(4, rows, w);
            rst   = 1'b0;
            start = 1'b1;
            mode  = v.mode;
            body(v, 0, nwr);
        end
        @(negedge clk);
        chk("idle_after_done", {w_busy, w_done, w_rd_en, w_wr_en}, 0);
    endtask

    vec_t vecs [9];
    int   satv;

    initial begin
`ifdef TV_DIFF_SAT_EN
        satv = 32767;
`else
        satv = 65535;
`endif
        //          sel mode pat mid abort done  spot1          spot2
        vecs[0] = '{0, 0, 0, 0, 0,  99,  0, 0, 1,      1, 31, 0};
        vecs[1] = '{0, 1, 1, 0, 0,  99,  0, 0, 1,      95, 5, 0};
        vecs[2] = '{0, 0, 2, 0, 0,  99,  0, 0, satv,   0, 1, 32769};
        vecs[3] = '{0, 0, 4, 1, 0,  99,  1, 31, 0,     95, 31, 0};
        vecs[4] = '{0, 1, 4, 0, 0,  99,  95, 0, 0,     94, 31, 0};
        vecs[5] = '{0, 0, 4, 0, 40, 99,  -1, 0, 0,     -1, 0, 0};
        vecs[6] = '{1, 0, 3, 0, 0,  18,  0, 0, 1,      2, 3, 0};
        vecs[7] = '{1, 1, 4, 0, 0,  18,  14, 3, 0,     12, 0, 0};
        vecs[8] = '{1, 1, 3, 0, 0,  18,  0, 0, 12,     14, 3, 0};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state_a", {w_rd_en, w_wr_en, w_busy, w_done,
                              w_rd_addr, w_wr_addr, |w_wr_data}, 0);
        sel = 1'b1;
        #1;
        chk("reset_state_b", {w_rd_en, w_wr_en, w_busy, w_done,
                              w_rd_addr, w_wr_addr, |w_wr_data}, 0);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
